// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decodes stage enables and bubble flushes from a
// small FSM plus the current hazard inputs, and keeps saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             ex_dren,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_redirect,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DWAIT = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0] state_q, state_d;

  logic active;
  logic freeze;
  logic load_use;
  logic redirect_take;

  assign active   = (state_q == ST_RUN) || (state_q == ST_DWAIT);
  assign freeze   = mem_dreq && !dhit;
  assign load_use = ex_dren && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
  // A redirect only counts when nothing above it in priority holds EX in place.
  assign redirect_take = active && !mem_halt && !freeze && ex_redirect;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halt       = 1'b0;
    case (state_q)
      ST_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
      end
      ST_HALT: begin
        halt    = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        // RUN and DWAIT share the same priority decode; only the next state differs.
        if (mem_halt) begin
          state_d = ST_HALT;
        end else if (freeze) begin
          state_d = ST_DWAIT;
        end else begin
          state_d = ST_RUN;
          if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
          end else if (!ihit) begin
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Index 0 counts stalled-PC cycles, index 1 counts redirect flushes.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign cnt_inc[0] = active && !pc_en;
  assign cnt_inc[1] = redirect_take;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; a rule-level model fills a
// scoreboard queue that a negedge monitor drains and compares.
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic       rst_n;
    logic       ihit;
    logic       dhit;
    logic       mem_dreq;
    logic       ex_dren;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       redir;
    logic       mhalt;
  } stim_t;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic          CLK;
  logic          nRST;
  logic          ihit, dhit, mem_dreq, ex_dren, ex_redirect, mem_halt;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_dren(ex_dren), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_redirect(ex_redirect), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  // Model: processor is either initialising, halted, or running (waiting on
  // data looks exactly like running from the outside).
  bit    m_init = 1'b1;
  bit    m_halted = 1'b0;
  int    m_stall = 0;
  int    m_flush = 0;
  stim_t prev;

  localparam int C_INIT = 0, C_HALTED = 1, C_MHALT = 2, C_FREEZE = 3,
                 C_REDIR = 4, C_LOADUSE = 5, C_FMISS = 6, C_NORMAL = 7;

  function automatic int classify(input stim_t s);
    if (!s.rst_n || m_init) return C_INIT;
    if (m_halted) return C_HALTED;
    if (s.mhalt) return C_MHALT;
    if (s.mem_dreq && !s.dhit) return C_FREEZE;
    if (s.redir) return C_REDIR;
    if (s.ex_dren && s.ex_rt != 0 && (s.ex_rt == s.id_rs || s.ex_rt == s.id_rt))
      return C_LOADUSE;
    if (!s.ihit) return C_FMISS;
    return C_NORMAL;
  endfunction

  // ctrl = {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halt}
  function automatic logic [7:0] ctrl_of(input int c);
    case (c)
      C_INIT:    return 8'b00000_11_0;
      C_HALTED:  return 8'b00000_00_1;
      C_MHALT:   return 8'b00000_00_0;
      C_FREEZE:  return 8'b00000_00_0;
      C_REDIR:   return 8'b11111_11_0;
      C_LOADUSE: return 8'b00111_01_0;
      C_FMISS:   return 8'b01111_10_0;
      default:   return 8'b11111_00_0;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_update(input stim_t s);
    int c;
    c = classify(s);
    if (!s.rst_n) begin
      m_init = 1'b1; m_halted = 1'b0; m_stall = 0; m_flush = 0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else begin
      if (c == C_MHALT) m_halted = 1'b1;
      if (c == C_MHALT || c == C_FREEZE || c == C_LOADUSE || c == C_FMISS)
        m_stall = sat_inc(m_stall);
      if (c == C_REDIR) m_flush = sat_inc(m_flush);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge CLK);
    model_update(prev);
    #1;
    nRST = s.rst_n; ihit = s.ihit; dhit = s.dhit; mem_dreq = s.mem_dreq;
    ex_dren = s.ex_dren; ex_rt = s.ex_rt; id_rs = s.id_rs; id_rt = s.id_rt;
    ex_redirect = s.redir; mem_halt = s.mhalt;
    // Asynchronous reset takes effect within the cycle it is asserted.
    if (!s.rst_n) begin
      m_init = 1'b1; m_halted = 1'b0; m_stall = 0; m_flush = 0;
    end
    e.ctrl  = ctrl_of(classify(s));
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    sb_q.push_back(e);
    prev = s;
    cyc++;
  endtask

  function automatic stim_t mk(input logic r, input logic ih, input logic dh,
                               input logic dq, input logic dr, input logic [4:0] rt,
                               input logic [4:0] rs, input logic [4:0] rt2,
                               input logic rd, input logic mh);
    stim_t s;
    s.rst_n = r; s.ihit = ih; s.dhit = dh; s.mem_dreq = dq; s.ex_dren = dr;
    s.ex_rt = rt; s.id_rs = rs; s.id_rt = rt2; s.redir = rd; s.mhalt = mh;
    return s;
  endfunction

  task automatic chk_now(input string name, input int got, input int want);
    @(negedge CLK);
    #1;
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: the controller presents a response every cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt} !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b", cyc,
                 {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt}, e.ctrl);
      end
      checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        failures++;
        $display("FAIL counters cyc=%0d got=%0d/%0d want=%0d/%0d", cyc,
                 stall_cnt, flush_cnt, e.stall, e.flush);
      end
    end
  end

  task automatic reset_seq();
    repeat (2) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    stim_t s;
    prev = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; ex_dren = 1'b0;
    ex_rt = '0; id_rs = '0; id_rt = '0; ex_redirect = 1'b0; mem_halt = 1'b0;

    // Reset release, INIT then RUN
    reset_seq();
    repeat (3) step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("txn reset_release cycles=%0d", cyc);

    // Data-miss freeze for three cycles then completion
    repeat (3) step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_now("freeze_stall_cnt", int'(stall_cnt), 3);
    $display("txn dfreeze cycles=%0d", cyc);

    // Load-use on r5, bubble clears it, then load to r0 has no hazard
    step(mk(1, 1, 0, 0, 1, 5, 5, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 5, 0, 0, 0));
    step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    $display("txn load_use cycles=%0d", cyc);

    // Redirect overrides load-use and fetch miss
    step(mk(1, 0, 0, 0, 1, 5, 5, 0, 1, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_now("redirect_flush_cnt", int'(flush_cnt), 1);
    $display("txn redirect cycles=%0d", cyc);

    // Redirect held during freeze, taken on unfreeze
    repeat (2) step(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    step(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("txn redirect_in_freeze cycles=%0d", cyc);

    // Halt is sticky through ihit toggling, cleared only by reset
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++) step(mk(1, i[0], 0, 0, 0, 0, 0, 0, 0, 0));
    chk_now("halt_sticky", int'(halt), 1);
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("txn halt cycles=%0d", cyc);

    // Reset asserted mid-freeze
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    $display("txn reset_in_dwait cycles=%0d", cyc);

    // Drive both counters into saturation
    repeat (20) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (20) step(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    chk_now("stall_saturated", int'(stall_cnt), SAT);
    chk_now("flush_saturated", int'(flush_cnt), SAT);
    $display("txn saturation cycles=%0d", cyc);

    // Randomized traffic with small register numbers so hazards collide often
    for (int i = 0; i < 1500; i++) begin
      s.rst_n    = ($urandom_range(0, 99) != 0);
      s.ihit     = ($urandom_range(0, 3) != 0);
      s.dhit     = $urandom_range(0, 1) != 0;
      s.mem_dreq = $urandom_range(0, 2) == 0;
      s.ex_dren  = $urandom_range(0, 1) != 0;
      s.ex_rt    = 5'($urandom_range(0, 3));
      s.id_rs    = 5'($urandom_range(0, 3));
      s.id_rt    = 5'($urandom_range(0, 3));
      s.redir    = $urandom_range(0, 5) == 0;
      s.mhalt    = $urandom_range(0, 59) == 0;
      step(s);
    end
    $display("txn random cycles=%0d", cyc);

    @(negedge CLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
